// File: rtl/axis_lfsr_pkg.sv
// Shared definitions for the AXI-Stream LFSR checker: register offsets, reset taps,
// checker states and the LFSR step function.
package axis_lfsr_pkg;

  localparam logic [7:0] REG_CTRL   = 8'h0;
  localparam logic [7:0] REG_TAPS   = 8'h4;
  localparam logic [7:0] REG_BEATS  = 8'h8;
  localparam logic [7:0] REG_STATUS = 8'hC;

  localparam logic [7:0] TAPS_RST = 8'hB8;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    TRACK
  } state_t;

  // One Fibonacci step: shift left, feedback bit is the parity of the tapped bits.
  function automatic logic [7:0] lfsr_next(input logic [7:0] v, input logic [7:0] taps);
    return {v[6:0], ^(v & taps)};
  endfunction

endpackage

// File: rtl/axis_lfsr_check_core.sv
// Sync/track state machine, expected-value register and saturating beat/error counters
// for the LFSR stream checker.
module axis_lfsr_check_core
  import axis_lfsr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [7:0]            taps,
  input  logic [DATA_WIDTH-1:0] tdata,
  input  logic                  tvalid,
  input  logic                  tready,
  output logic [31:0]           beats,
  output logic [15:0]           err_count,
  output logic                  sticky,
  output logic                  locked
);

  state_t      state;
  logic [7:0]  expected;
  logic        beat_c;
  logic        upper_zero_c;
  logic [31:0] beats_inc_c;
  logic [15:0] err_inc_c;

  assign beat_c       = tvalid && tready;
  assign upper_zero_c = (tdata[DATA_WIDTH-1:8] == '0);
  assign beats_inc_c  = (beats == '1) ? beats : beats + 32'd1;
  assign err_inc_c    = (err_count == '1) ? err_count : err_count + 16'd1;

  // A beat accepted while IDLE is still enabled is handled as the first SYNC beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      expected  <= 8'd0;
      beats     <= 32'd0;
      err_count <= 16'd0;
      sticky    <= 1'b0;
      locked    <= 1'b0;
    end else if (clear) begin
      beats     <= 32'd0;
      err_count <= 16'd0;
      sticky    <= 1'b0;
      locked    <= 1'b0;
      state     <= enable ? SYNC : IDLE;
    end else if (!enable) begin
      state  <= IDLE;
      locked <= 1'b0;
    end else begin
      if (beat_c) begin
        beats <= beats_inc_c;
      end
      case (state)
        TRACK: begin
          if (beat_c) begin
            if (tdata != DATA_WIDTH'(expected)) begin
              err_count <= err_inc_c;
              sticky    <= 1'b1;
            end
            expected <= lfsr_next(tdata[7:0], taps);
          end
        end
        default: begin
          state <= SYNC;
          if (beat_c) begin
            if ((tdata[7:0] != 8'd0) && upper_zero_c) begin
              expected <= lfsr_next(tdata[7:0], taps);
              locked   <= 1'b1;
              state    <= TRACK;
            end else begin
              err_count <= err_inc_c;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/axis_lfsr_checker.sv
// AXI-Stream LFSR checker: AXI-Lite register file (CTRL/TAPS/BEATS/STATUS) around the
// checking core; the stream is accepted whenever the checker is enabled.
module axis_lfsr_checker
  import axis_lfsr_pkg::*;
#(
  parameter int unsigned C_AXIL_ADDR_WIDTH = 4,
  parameter int unsigned C_AXIL_DATA_WIDTH = 32
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic [C_AXIL_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                         s_axi_awvalid,
  output logic                         s_axi_awready,
  input  logic [C_AXIL_DATA_WIDTH-1:0] s_axi_wdata,
  input  logic                         s_axi_wvalid,
  output logic                         s_axi_wready,
  output logic [1:0]                   s_axi_bresp,
  output logic                         s_axi_bvalid,
  input  logic                         s_axi_bready,
  input  logic [C_AXIL_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                         s_axi_arvalid,
  output logic                         s_axi_arready,
  output logic [C_AXIL_DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]                   s_axi_rresp,
  output logic                         s_axi_rvalid,
  input  logic                         s_axi_rready,
  input  logic [C_AXIL_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready
);

  localparam int unsigned AW = C_AXIL_ADDR_WIDTH;
  localparam int unsigned DW = C_AXIL_DATA_WIDTH;

  logic          enable;
  logic [7:0]    taps;
  logic [AW-1:0] rd_addr;
  logic [31:0]   beats;
  logic [15:0]   err_count;
  logic          sticky;
  logic          locked;
  logic          wr_go_c;
  logic          rd_go_c;
  logic          clear_c;
  logic [DW-1:0] rdata_c;
  logic          unused_wdata_c;

  assign wr_go_c        = s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid && !s_axi_awready;
  assign rd_go_c        = s_axi_arvalid && !s_axi_rvalid && !s_axi_arready;
  assign clear_c        = wr_go_c && (s_axi_awaddr == AW'(REG_CTRL)) && s_axi_wdata[1];
  assign unused_wdata_c = ^s_axi_wdata[DW-1:8];

  assign s_axi_bresp   = 2'b00;
  assign s_axi_rresp   = 2'b00;
  assign s_axis_tready = enable;

  // Read mux; clear is a pulse and always reads back as 0.
  always_comb begin
    rdata_c = '0;
    case (rd_addr)
      AW'(REG_CTRL):   rdata_c = DW'(enable);
      AW'(REG_TAPS):   rdata_c = DW'(taps);
      AW'(REG_BEATS):  rdata_c = DW'(beats);
      AW'(REG_STATUS): rdata_c = DW'({locked, sticky, 14'd0, err_count});
      default:         rdata_c = '0;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      rd_addr       <= '0;
      enable        <= 1'b0;
      taps          <= TAPS_RST;
    end else begin
      s_axi_awready <= wr_go_c;
      s_axi_wready  <= wr_go_c;
      if (wr_go_c) begin
        if (s_axi_awaddr == AW'(REG_CTRL)) begin
          enable <= s_axi_wdata[0];
        end else if (s_axi_awaddr == AW'(REG_TAPS)) begin
          taps <= s_axi_wdata[7:0];
        end
      end
      if (s_axi_awready) begin
        s_axi_bvalid <= 1'b1;
      end else if (s_axi_bvalid && s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
      end

      s_axi_arready <= rd_go_c;
      if (rd_go_c) begin
        rd_addr <= s_axi_araddr;
      end
      if (s_axi_arready) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= rdata_c;
      end else if (s_axi_rvalid && s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end
    end
  end

  axis_lfsr_check_core #(
    .DATA_WIDTH(DW)
  ) u_core (
    .clk      (aclk),
    .rst      (areset),
    .enable   (enable),
    .clear    (clear_c),
    .taps     (taps),
    .tdata    (s_axis_tdata),
    .tvalid   (s_axis_tvalid),
    .tready   (s_axis_tready),
    .beats    (beats),
    .err_count(err_count),
    .sticky   (sticky),
    .locked   (locked)
  );

endmodule

// File: tb/tb_axis_lfsr_checker.sv
// Self-checking bench for axis_lfsr_checker: directed register/stream scenarios plus a
// randomized stream with corruptions, taps changes and clears against a reference model.
module tb_axis_lfsr_checker;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;

  logic          aclk = 1'b0;
  logic          areset;
  logic [AW-1:0] s_axi_awaddr;
  logic          s_axi_awvalid;
  logic          s_axi_awready;
  logic [DW-1:0] s_axi_wdata;
  logic          s_axi_wvalid;
  logic          s_axi_wready;
  logic [1:0]    s_axi_bresp;
  logic          s_axi_bvalid;
  logic          s_axi_bready;
  logic [AW-1:0] s_axi_araddr;
  logic          s_axi_arvalid;
  logic          s_axi_arready;
  logic [DW-1:0] s_axi_rdata;
  logic [1:0]    s_axi_rresp;
  logic          s_axi_rvalid;
  logic          s_axi_rready;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;

  axis_lfsr_checker #(
    .C_AXIL_ADDR_WIDTH(AW),
    .C_AXIL_DATA_WIDTH(DW)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .s_axi_awaddr (s_axi_awaddr),
    .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata  (s_axi_wdata),
    .s_axi_wvalid (s_axi_wvalid),
    .s_axi_wready (s_axi_wready),
    .s_axi_bresp  (s_axi_bresp),
    .s_axi_bvalid (s_axi_bvalid),
    .s_axi_bready (s_axi_bready),
    .s_axi_araddr (s_axi_araddr),
    .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rdata  (s_axi_rdata),
    .s_axi_rresp  (s_axi_rresp),
    .s_axi_rvalid (s_axi_rvalid),
    .s_axi_rready (s_axi_rready),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready)
  );

  always #5 aclk = ~aclk;

  int tests = 0;
  int fails = 0;

  // Reference model state: what software should observe through the registers.
  bit          m_en;
  bit          m_locked;
  bit          m_sticky;
  logic [7:0]  m_taps;
  logic [7:0]  m_exp;
  longint      m_beats;
  int          m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] nxt(input logic [7:0] v, input logic [7:0] t);
    int s;
    s = (int'(v) * 2) % 256 + ($countones(v & t) % 2);
    return 8'(s);
  endfunction

  function automatic logic [31:0] model_status();
    return {m_locked, m_sticky, 14'd0, 16'(m_err)};
  endfunction

  task automatic model_err();
    if (m_err < 65535) m_err++;
  endtask

  task automatic model_clear();
    m_beats  = 0;
    m_err    = 0;
    m_sticky = 0;
    m_locked = 0;
  endtask

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data);
    if (addr == 32'h0) begin
      if (data[1]) model_clear();
      m_en = data[0];
      if (!m_en) m_locked = 0;
    end else if (addr == 32'h4) begin
      m_taps = data[7:0];
    end
  endtask

  task automatic model_beat(input logic [31:0] d);
    if (m_beats < 64'hFFFF_FFFF) m_beats++;
    if (!m_locked) begin
      if (d[7:0] != 8'd0 && (d >> 8) == 32'd0) begin
        m_exp    = nxt(d[7:0], m_taps);
        m_locked = 1;
      end else begin
        model_err();
      end
    end else begin
      if (d != {24'd0, m_exp}) begin
        model_err();
        m_sticky = 1;
      end
      m_exp = nxt(d[7:0], m_taps);
    end
  endtask

  task automatic aw_start(input logic [31:0] addr, input logic [31:0] data);
    @(negedge aclk);
    s_axi_awaddr  = AW'(addr);
    s_axi_wdata   = data;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b1;
  endtask

  task automatic aw_handshake();
    int n = 0;
    while (!s_axi_awready && n < 50) begin
      @(negedge aclk);
      n++;
    end
    if (!s_axi_awready) check("aw_timeout", 32'(s_axi_awready), 32'd1);
    else check("wready_with_awready", 32'(s_axi_wready), 32'd1);
    @(posedge aclk);
    #1;
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
  endtask

  task automatic b_handshake();
    int n = 0;
    while (!s_axi_bvalid && n < 50) begin
      @(negedge aclk);
      n++;
    end
    if (!s_axi_bvalid) check("b_timeout", 32'(s_axi_bvalid), 32'd1);
    else check("bresp", 32'(s_axi_bresp), 32'd0);
    @(posedge aclk);
    #1;
  endtask

  task automatic axil_write(input logic [31:0] addr, input logic [31:0] data);
    aw_start(addr, data);
    aw_handshake();
    model_write(addr, data);
    b_handshake();
  endtask

  task automatic axil_read(input logic [31:0] addr, output logic [31:0] data);
    int n = 0;
    @(negedge aclk);
    s_axi_araddr  = AW'(addr);
    s_axi_arvalid = 1'b1;
    while (!s_axi_arready && n < 50) begin
      @(negedge aclk);
      n++;
    end
    if (!s_axi_arready) check("ar_timeout", 32'(s_axi_arready), 32'd1);
    @(posedge aclk);
    #1;
    s_axi_arvalid = 1'b0;
    n = 0;
    while (!s_axi_rvalid && n < 50) begin
      @(negedge aclk);
      n++;
    end
    if (!s_axi_rvalid) check("r_timeout", 32'(s_axi_rvalid), 32'd1);
    else check("rresp", 32'(s_axi_rresp), 32'd0);
    data = s_axi_rdata;
    @(posedge aclk);
    #1;
  endtask

  task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    axil_read(addr, d);
    check(tag, d, exp);
  endtask

  task automatic send_beat(input logic [31:0] d);
    int n = 0;
    @(negedge aclk);
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    while (!s_axis_tready && n < 50) begin
      @(negedge aclk);
      n++;
    end
    if (!s_axis_tready) begin
      check("tready_timeout", 32'(s_axis_tready), 32'd1);
      s_axis_tvalid = 1'b0;
    end else begin
      @(posedge aclk);
      #1;
      s_axis_tvalid = 1'b0;
      model_beat(d);
    end
  endtask

  initial begin
    logic [31:0] seq1 [6] = '{32'h01, 32'h02, 32'h04, 32'h08, 32'h11, 32'h23};
    logic [31:0] seq2 [5] = '{32'h01, 32'h02, 32'h05, 32'h08, 32'h11};
    logic [31:0] seq3 [4] = '{32'h00, 32'h101, 32'h04, 32'h08};
    logic [7:0]  g;
    logic [31:0] d;
    int          r;

    areset = 1'b1;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b1; s_axi_araddr = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0;
    m_en = 0; m_taps = 8'hB8; m_exp = 8'h00;
    model_clear();
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;

    // Reset state.
    @(negedge aclk);
    check("rst_tready", 32'(s_axis_tready), 32'd0);
    check("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
    check("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
    check("rst_awready", 32'(s_axi_awready), 32'd0);
    check("rst_rdata", s_axi_rdata, 32'd0);
    read_check("rst_taps", 32'h4, 32'h0000_00B8);
    read_check("rst_status", 32'hC, 32'h0000_0000);
    read_check("rst_beats", 32'h8, 32'h0000_0000);
    read_check("rst_ctrl", 32'h0, 32'h0000_0000);

    // Clean stream locks with no errors.
    axil_write(32'h0, 32'h1);
    @(negedge aclk);
    check("en_tready", 32'(s_axis_tready), 32'd1);
    foreach (seq1[i]) send_beat(seq1[i]);
    read_check("seq1_beats", 32'h8, 32'd6);
    read_check("seq1_status", 32'hC, 32'h8000_0000);
    read_check("ctrl_after_en", 32'h0, 32'h1);

    // One corrupted beat costs two errors and sets sticky.
    axil_write(32'h0, 32'h3);
    foreach (seq2[i]) send_beat(seq2[i]);
    read_check("seq2_beats", 32'h8, 32'd5);
    read_check("seq2_status", 32'hC, 32'hC000_0002);

    // Zero and non-zero upper bits are rejected while syncing.
    axil_write(32'h0, 32'h3);
    foreach (seq3[i]) send_beat(seq3[i]);
    read_check("seq3_beats", 32'h8, 32'd4);
    read_check("seq3_status", 32'hC, 32'h8000_0002);

    // Clear in the same cycle a beat is accepted: the beat is dropped.
    aw_start(32'h0, 32'h3);
    s_axis_tdata  = 32'h55;
    s_axis_tvalid = 1'b1;
    @(posedge aclk);
    #1 s_axis_tvalid = 1'b0;
    aw_handshake();
    model_write(32'h0, 32'h3);
    b_handshake();
    read_check("clr_beats", 32'h8, 32'd0);
    read_check("clr_status", 32'hC, 32'h0000_0000);
    send_beat(32'h04);
    send_beat(32'h08);
    read_check("resync_beats", 32'h8, 32'd2);
    read_check("resync_status", 32'hC, 32'h8000_0000);

    // Back-to-back writes with bready low stall the second write.
    s_axi_bready = 1'b0;
    aw_start(32'h4, 32'hB8);
    aw_handshake();
    model_write(32'h4, 32'hB8);
    aw_start(32'h4, 32'h8E);
    for (int i = 0; i < 6; i++) begin
      @(negedge aclk);
      check("aw_blocked", 32'(s_axi_awready), 32'd0);
    end
    check("bvalid_held", 32'(s_axi_bvalid), 32'd1);
    s_axi_bready = 1'b1;
    aw_handshake();
    model_write(32'h4, 32'h8E);
    b_handshake();
    read_check("taps_b2b", 32'h4, 32'h0000_008E);
    read_check("unmapped_rd", 32'h2, 32'h0000_0000);

    // Randomized stream against the model.
    axil_write(32'h0, 32'h3);
    g = 8'(1 + $urandom_range(0, 254));
    for (int it = 0; it < 600; it++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        axil_write(32'h4, {24'd0, 8'h80 | 8'($urandom_range(0, 127))});
      end else if (r < 4) begin
        axil_write(32'h0, 32'h3);
      end else if (r < 6) begin
        axil_write(32'h0, 32'h0);
        @(negedge aclk);
        check("dis_tready", 32'(s_axis_tready), 32'd0);
        read_check("dis_status", 32'hC, model_status());
        axil_write(32'h0, 32'h1);
      end else if (r < 10) begin
        read_check("rnd_beats", 32'h8, 32'(m_beats));
        read_check("rnd_status", 32'hC, model_status());
      end else begin
        d = {24'd0, g};
        r = $urandom_range(0, 99);
        if (r < 4) d = d ^ (32'd1 << $urandom_range(0, 7));
        else if (r < 6) d = d | (32'd1 << $urandom_range(8, 31));
        send_beat(d);
        g = nxt(g, m_taps);
        if (g == 8'd0) g = 8'(1 + $urandom_range(0, 254));
        if ($urandom_range(0, 3) == 0) @(negedge aclk);
      end
    end
    read_check("end_beats", 32'h8, 32'(m_beats));
    read_check("end_status", 32'hC, model_status());

    // Reset while a read response is outstanding.
    s_axi_rready = 1'b0;
    @(negedge aclk);
    s_axi_araddr  = AW'(32'h8);
    s_axi_arvalid = 1'b1;
    for (int n = 0; n < 50 && !s_axi_rvalid; n++) begin
      @(negedge aclk);
      if (s_axi_arready) s_axi_arvalid = 1'b0;
    end
    s_axi_arvalid = 1'b0;
    check("pre_rst_rvalid", 32'(s_axi_rvalid), 32'd1);
    #2 areset = 1'b1;
    #1;
    check("mid_rst_rvalid", 32'(s_axi_rvalid), 32'd0);
    check("mid_rst_tready", 32'(s_axis_tready), 32'd0);
    @(posedge aclk);
    #1 areset = 1'b0;
    s_axi_rready = 1'b1;
    m_en = 0; m_taps = 8'hB8;
    model_clear();
    read_check("post_rst_taps", 32'h4, 32'h0000_00B8);
    read_check("post_rst_beats", 32'h8, 32'd0);
    read_check("post_rst_status", 32'hC, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axis_lfsr_checker.md
Name: axis_lfsr_checker

Overview:
- AXI-Stream sink that receives the 8-bit LFSR stream (zero-padded to 32 bits) from the LFSR generator and checks every beat against the expected sequence.
- Self-synchronises on the first valid beat, then counts accepted beats and mismatches.
- Control and status registers are exposed through an AXI-Lite slave, so software can run end-to-end loopback tests of the generator.

Parameters:
- C_AXIL_ADDR_WIDTH, 4, AXI-Lite address width.
- C_AXIL_DATA_WIDTH, 32, AXI-Lite and AXI-Stream data width; must be ≥ 32.

Ports:
- aclk  in  1  clock; all logic rises on posedge.
- areset  in  1  asynchronous, active-high reset.
- s_axi_awaddr/awvalid/awready, s_axi_wdata/wvalid/wready, s_axi_bresp/bvalid/bready  AXI-Lite write channels, standard widths.
- s_axi_araddr/arvalid/arready, s_axi_rdata/rresp/rvalid/rready  AXI-Lite read channels, standard widths.
- s_axis_tdata  in  C_AXIL_DATA_WIDTH  stream data; [7:0] is the LFSR value, upper bits must be 0.
- s_axis_tvalid  in  1  stream valid.
- s_axis_tready  out  1  stream ready.

Behaviour:
- Reset: all ready/valid outputs 0; bresp, rresp, rdata 0; enable 0; taps 0xB8; counters 0; state IDLE.
- Register map (full-address compare; any other address is unmapped: writes ignored, reads 0, response always OKAY 2'b00):
  - 0x0 CTRL: bit0 enable (RW); bit1 clear (write-1 pulse, reads 0).
  - 0x4 TAPS: [7:0] RW.
  - 0x8 BEATS: RO, accepted-beat count, saturates at 0xFFFFFFFF.
  - 0xC STATUS: RO; [15:0] error count, saturating at 0xFFFF; bit30 sticky error; bit31 locked.
- AXI-Lite write:
  - Accepted only when awvalid && wvalid && !bvalid.
  - awready and wready pulse high together for 1 cycle; the register updates in that same edge.
  - bvalid rises the next cycle and holds until bready.
- AXI-Lite read:
  - Accepted when arvalid && !rvalid && !arready; arready pulses 1 cycle.
  - rvalid and rdata follow 1 cycle later; rdata is held stable until rready.
- s_axis_tready = enable (registered). A beat is accepted on tvalid && tready.
- lfsr_next(v) = {v[6:0], ^(v & taps)}.
- FSM:
  - IDLE: enable=0. enable=1 → SYNC.
  - SYNC: on an accepted beat, if tdata[7:0] != 0 and the upper bits are 0, then expected <= lfsr_next(tdata[7:0]), locked <= 1, go to TRACK. Otherwise err_count++ and stay in SYNC.
  - TRACK: each accepted beat is compared with {0, expected}. On mismatch: err_count++, sticky <= 1. In both cases expected <= lfsr_next(tdata[7:0]). Consequence: a single corrupted beat yields exactly 2 errors, then the checker resyncs.
  - enable=0 from any state → IDLE, locked <= 0. Counters and sticky hold.
- BEATS increments on every accepted beat, in SYNC and in TRACK.
- Clear: zeroes BEATS, err_count, sticky and locked, and returns to SYNC if enabled, else IDLE.
- A beat accepted in the same cycle as a clear is dropped: it is not counted and not checked.
- A TAPS write takes effect on the next accepted beat. An expected value already computed is not recomputed.
- Reset mid-transfer: everything returns to reset values immediately; an outstanding bvalid or rvalid is dropped.

Decomposition:
- Package axis_lfsr_pkg:
  - register offsets CTRL/TAPS/BEATS/STATUS
  - TAPS_RST=8'hB8
  - state enum {IDLE, SYNC, TRACK}
  - function lfsr_next(v, taps)
- Sub-module axis_lfsr_check_core: FSM, expected register and counters. The top level holds the AXI-Lite register file and instantiates the core.

Test Plan:
- Reset, read TAPS → 0x000000B8; read STATUS → 0x00000000; s_axis_tready=0.
- Write CTRL=1, stream 0x01,0x02,0x04,0x08,0x11,0x23 → BEATS=6, STATUS=0x80000000 (locked, 0 errors).
- Stream 0x01,0x02,0x05,0x08,0x11 → error count 2, STATUS=0xC0000002.
- First beat 0x00, then 0x00000101, then 0x04,0x08 → error count 2; lock is taken on 0x04; 0x08 passes.
- Write CTRL=3 (clear) in the same cycle a beat is accepted → BEATS=0, STATUS=0; the beat is ignored and the next beat resyncs.
- Back-to-back writes with bready held low → awready stays 0 until bready; read of an unmapped address 0x2 → rdata=0, rresp=0.
